// File: rtl/ocm_core_port.sv
// ==== ocm_core_port : per-core OCM requester, loads/stores and atomic RMW under one grant ====
// ==== rev 1.0 ====
`default_nettype none

module ocm_core_port #(
   parameter int          ADDR_BITS = 12,
   parameter logic [31:0] OCM_BASE  = 32'h0000_8000,
   parameter logic [31:0] OCM_MASK  = 32'hFFFF_C000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_access,
   input  logic [31:0]          i_addr,
   input  logic [31:0]          i_wdata,
   input  logic [3:0]           i_dm_write,
   input  logic [2:0]           i_amo_op,
   output logic                 o_stall,
   output logic                 o_ack,
   output logic [31:0]          o_rdata,
   output logic                 o_req,
   output logic                 o_done,
   input  logic                 i_grant,
   output logic [31:0]          o_data,
   output logic [3:0]           o_dm_write,
   output logic [ADDR_BITS-1:0] o_addr,
   input  logic [31:0]          i_rdata,
   input  logic                 i_valid_data,
   input  logic                 i_valid_write_data
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_XFER    = 3'd1;
   localparam logic [2:0] S_AMO_GAP = 3'd2;
   localparam logic [2:0] S_XFER_W  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [2:0] c_AMO_SWAP = 3'd1;
   localparam logic [2:0] c_AMO_ADD  = 3'd2;
   localparam logic [2:0] c_AMO_AND  = 3'd3;
   localparam logic [2:0] c_AMO_OR   = 3'd4;
   localparam logic [2:0] c_AMO_XOR  = 3'd5;

   logic [2:0]           r_state;
   logic [2:0]           w_next;
   logic [2:0]           r_amo_op;
   logic [ADDR_BITS-1:0] r_addr;
   logic [31:0]          r_data;
   logic [3:0]           r_dm_write;
   logic [31:0]          r_rdata;
   logic                 r_ack;
   logic                 w_hit;
   logic                 w_accept;
   logic                 w_is_amo;
   logic [31:0]          w_amo_result;
   logic                 w_unused_grant;

   // Progress is tracked from the OCM valid pulses alone; the grant is informational.
   assign w_unused_grant = i_grant;

   assign w_hit    = i_access & ((i_addr & OCM_MASK) == OCM_BASE);
   assign w_accept = w_hit & (r_state == S_IDLE) & ~r_ack;
   assign w_is_amo = (r_amo_op != 3'd0);

   always_comb begin
      w_amo_result = r_data;
      case (r_amo_op)
         c_AMO_SWAP: w_amo_result = r_data;
         c_AMO_ADD:  w_amo_result = i_rdata + r_data;
         c_AMO_AND:  w_amo_result = i_rdata & r_data;
         c_AMO_OR:   w_amo_result = i_rdata | r_data;
         c_AMO_XOR:  w_amo_result = i_rdata ^ r_data;
         default:    w_amo_result = r_data;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = S_XFER;
         S_XFER: begin
            if (!w_is_amo && (i_valid_data || i_valid_write_data)) w_next = S_DONE;
            else if (w_is_amo && i_valid_data)                     w_next = S_AMO_GAP;
         end
         S_AMO_GAP: w_next = S_XFER_W;
         S_XFER_W:  if (i_valid_write_data) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_req   = (r_state != S_IDLE);
      o_done  = (r_state == S_DONE);
      o_stall = w_accept | (r_state != S_IDLE);
   end

   // The AMO keeps o_req high through the gap so the grant is never released mid-RMW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_amo_op   <= 3'd0;
         r_addr     <= '0;
         r_data     <= 32'd0;
         r_dm_write <= 4'd0;
         r_rdata    <= 32'd0;
         r_ack      <= 1'b0;
      end else begin
         r_ack <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr     <= i_addr[ADDR_BITS+1:2];
                  r_data     <= i_wdata;
                  r_amo_op   <= i_amo_op;
                  r_dm_write <= (i_amo_op == 3'd0) ? i_dm_write : 4'd0;
               end
            end
            S_XFER: begin
               if (!w_is_amo) begin
                  if (i_valid_data && (r_dm_write == 4'd0)) r_rdata <= i_rdata;
               end else if (i_valid_data) begin
                  r_rdata    <= i_rdata;
                  r_data     <= w_amo_result;
                  r_dm_write <= 4'hF;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ack      = r_ack;
   assign o_rdata    = r_rdata;
   assign o_data     = r_data;
   assign o_dm_write = r_dm_write;
   assign o_addr     = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_ocm_core_port.sv
// ==== tb_ocm_core_port : directed bench for ocm_core_port with a two-port OCM model ====
// ==== rev 1.0 ====
`default_nettype none

module tb_ocm_core_port;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        a0 = 1'b0, a1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic [3:0]  dm0 = '0, dm1 = '0;
   logic [2:0]  op0 = '0, op1 = '0;

   logic        stall0, ack0, req0, done0, stall1, ack1, req1, done1;
   logic [31:0] rdata0, data0, rdata1, data1;
   logic [3:0]  dmw0, dmw1;
   logic [11:0] oaddr0, oaddr1;

   logic        g0, g1, vd0, vw0, vd1, vw1;
   logic [31:0] m_rdata;

   logic        pl_en = 1'b0;
   logic [3:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   logic [31:0] mem [0:15];

   logic [2:0]  m_st;
   logic        m_own, m_rr;
   logic [11:0] m_addr;
   logic [3:0]  m_dm;
   logic [31:0] m_wd;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ocm_core_port u_p0 (
      .clk(clk), .rst(rst), .i_access(a0), .i_addr(addr0), .i_wdata(wdata0),
      .i_dm_write(dm0), .i_amo_op(op0), .o_stall(stall0), .o_ack(ack0), .o_rdata(rdata0),
      .o_req(req0), .o_done(done0), .i_grant(g0), .o_data(data0), .o_dm_write(dmw0),
      .o_addr(oaddr0), .i_rdata(m_rdata), .i_valid_data(vd0), .i_valid_write_data(vw0)
   );

   ocm_core_port u_p1 (
      .clk(clk), .rst(rst), .i_access(a1), .i_addr(addr1), .i_wdata(wdata1),
      .i_dm_write(dm1), .i_amo_op(op1), .o_stall(stall1), .o_ack(ack1), .o_rdata(rdata1),
      .o_req(req1), .o_done(done1), .i_grant(g1), .o_data(data1), .o_dm_write(dmw1),
      .o_addr(oaddr1), .i_rdata(m_rdata), .i_valid_data(vd1), .i_valid_write_data(vw1)
   );

   // OCM model: grant, latch (MEM_WAIT), access, valid pulse, MEM_DONE check for o_done.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st <= 3'd0; g0 <= 1'b0; g1 <= 1'b0;
         vd0 <= 1'b0; vw0 <= 1'b0; vd1 <= 1'b0; vw1 <= 1'b0;
         m_own <= 1'b0; m_rr <= 1'b0; m_rdata <= '0;
         m_addr <= '0; m_dm <= '0; m_wd <= '0;
      end else begin
         vd0 <= 1'b0; vw0 <= 1'b0; vd1 <= 1'b0; vw1 <= 1'b0;
         if (pl_en) mem[pl_idx] <= pl_val;
         case (m_st)
            3'd0: begin
               if (req0 && (!m_rr || !req1)) begin
                  m_own <= 1'b0; g0 <= 1'b1; m_rr <= 1'b1; m_st <= 3'd1;
               end else if (req1) begin
                  m_own <= 1'b1; g1 <= 1'b1; m_rr <= 1'b0; m_st <= 3'd1;
               end
            end
            3'd1: begin
               m_addr <= m_own ? oaddr1 : oaddr0;
               m_dm   <= m_own ? dmw1 : dmw0;
               m_wd   <= m_own ? data1 : data0;
               m_st   <= 3'd2;
            end
            3'd2: begin
               if (m_dm == 4'd0) begin
                  m_rdata <= mem[m_addr[3:0]];
                  if (m_own) vd1 <= 1'b1; else vd0 <= 1'b1;
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (m_dm[b]) mem[m_addr[3:0]][8*b +: 8] <= m_wd[8*b +: 8];
                  if (m_own) vw1 <= 1'b1; else vw0 <= 1'b1;
               end
               m_st <= 3'd3;
            end
            3'd3: m_st <= 3'd4;
            3'd4: begin
               if (m_own ? done1 : done0) begin
                  g0 <= 1'b0; g1 <= 1'b0; m_st <= 3'd0;
               end else begin
                  m_st <= 3'd1;
               end
            end
            default: m_st <= 3'd0;
         endcase
      end
   end

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Drives one port-0 access from the current negedge and records what it observes.
   task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] dm, input logic [2:0] op, input bit keep,
                            output int lat, output logic [31:0] rd, output int dones,
                            output int gaps, output bit stall_ok, output logic first_stall,
                            output logic [11:0] a_seen, output logic [3:0] dm_seen);
      bit seen_req;
      lat = -1; rd = 'x; dones = 0; gaps = 0; stall_ok = 1'b1;
      a_seen = 'x; dm_seen = 'x; seen_req = 1'b0;
      a0 = 1'b1; addr0 = addr; wdata0 = wdata; dm0 = dm; op0 = op;
      #1 first_stall = stall0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (done0) dones++;
         if (req0 && !seen_req) begin
            seen_req = 1'b1; a_seen = oaddr0; dm_seen = dmw0;
         end else if (seen_req && !req0 && !ack0) begin
            gaps++;
         end
         if (ack0) begin
            lat = k; rd = rdata0;
            if (stall0) stall_ok = 1'b0;
            break;
         end else if (!stall0) begin
            stall_ok = 1'b0;
         end
      end
      if (!keep) a0 = 1'b0;
   endtask

   int          lat, dones, gaps;
   logic [31:0] rd;
   bit          stall_ok;
   logic        fst;
   logic [11:0] aseen;
   logic [3:0]  dseen;

   task automatic test_reset;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if ({req0, done0, ack0, stall0} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b expected 0000", {req0, done0, ack0, stall0}); end
      n_cmp++; if (dmw0 !== 4'd0) begin n_bad++; $display("FAIL reset_dm_write: got %h expected 0", dmw0); end
      n_cmp++; if (data0 !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", data0); end
      n_cmp++; if (oaddr0 !== 12'd0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", oaddr0); end
      n_cmp++; if (rdata0 !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata0); end
   endtask

   task automatic test_plain_load;
      preload(4'd4, 32'hDEADBEEF);
      do_access(32'h0000_8010, 32'd0, 4'd0, 3'd0, 1'b0, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
      n_cmp++; if (fst !== 1'b1) begin n_bad++; $display("FAIL load_hit_stall: got %b expected 1", fst); end
      n_cmp++; if (aseen !== 12'h004) begin n_bad++; $display("FAIL load_addr: got %h expected 004", aseen); end
      n_cmp++; if (dseen !== 4'd0) begin n_bad++; $display("FAIL load_dm_write: got %h expected 0", dseen); end
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL load_latency: got %0d expected 6", lat); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL load_done_count: got %0d expected 1", dones); end
      n_cmp++; if (stall_ok !== 1'b1) begin n_bad++; $display("FAIL load_stall_window: got %b expected 1", stall_ok); end
   endtask

   task automatic test_byte_store;
      preload(4'd0, 32'h11223344);
      do_access(32'h0000_8003, 32'h0000_00AB, 4'b1000, 3'd0, 1'b0, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
      n_cmp++; if (aseen !== 12'h000) begin n_bad++; $display("FAIL store_addr: got %h expected 000", aseen); end
      n_cmp++; if (dseen !== 4'b1000) begin n_bad++; $display("FAIL store_dm_write: got %b expected 1000", dseen); end
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL store_latency: got %0d expected 6", lat); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL store_rdata_kept: got %h expected deadbeef", rd); end
      n_cmp++; if (mem[0] !== 32'h00223344) begin n_bad++; $display("FAIL store_mem: got %h expected 00223344", mem[0]); end
   endtask

   task automatic test_amo_add;
      preload(4'd5, 32'h7FFFFFFF);
      do_access(32'h0000_8014, 32'd1, 4'd0, 3'd2, 1'b0, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
      n_cmp++; if (dseen !== 4'd0) begin n_bad++; $display("FAIL amo_read_phase_dm: got %h expected 0", dseen); end
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL amo_latency: got %0d expected 10", lat); end
      n_cmp++; if (rd !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL amo_old: got %h expected 7fffffff", rd); end
      n_cmp++; if (mem[5] !== 32'h80000000) begin n_bad++; $display("FAIL amo_add_mem: got %h expected 80000000", mem[5]); end
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL amo_done_count: got %0d expected 1", dones); end
      n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL amo_req_gap: got %0d expected 0", gaps); end
   endtask

   task automatic test_amo_ops;
      logic [2:0]  ops [4];
      logic [31:0] init [4], opnd [4], expv [4];
      ops[0] = 3'd1; init[0] = 32'h12345678; opnd[0] = 32'hCAFEF00D; expv[0] = 32'hCAFEF00D;
      ops[1] = 3'd3; init[1] = 32'hF0F0F0F0; opnd[1] = 32'h0FF00FF0; expv[1] = 32'h00F000F0;
      ops[2] = 3'd4; init[2] = 32'hF0F0F0F0; opnd[2] = 32'h0FF00FF0; expv[2] = 32'hFFF0FFF0;
      ops[3] = 3'd5; init[3] = 32'hF0F0F0F0; opnd[3] = 32'h0FF00FF0; expv[3] = 32'hFF00FF00;
      for (int i = 0; i < 4; i++) begin
         preload(4'd6, init[i]);
         do_access(32'h0000_8018, opnd[i], 4'd0, ops[i], 1'b0, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
         n_cmp++; if (rd !== init[i]) begin n_bad++; $display("FAIL amo_op%0d_old: got %h expected %h", ops[i], rd, init[i]); end
         n_cmp++; if (mem[6] !== expv[i]) begin n_bad++; $display("FAIL amo_op%0d_mem: got %h expected %h", ops[i], mem[6], expv[i]); end
      end
   endtask

   task automatic test_non_hit;
      logic [31:0] addrs [3];
      bit quiet;
      addrs[0] = 32'h0000_1000; addrs[1] = 32'h0000_C000; addrs[2] = 32'h0000_7FFC;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a0 = 1'b1; addr0 = addrs[i]; dm0 = 4'd0; op0 = 3'd0;
         quiet = 1'b1;
         #1 if (stall0 || req0) quiet = 1'b0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (stall0 || req0 || ack0) quiet = 1'b0;
         end
         a0 = 1'b0;
         n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL non_hit_%h: got active expected idle", addrs[i]); end
      end
   endtask

   task automatic test_window_edge;
      preload(4'd15, 32'hA5A55A5A);
      do_access(32'h0000_BFFC, 32'd0, 4'd0, 3'd0, 1'b0, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
      n_cmp++; if (aseen !== 12'hFFF) begin n_bad++; $display("FAIL edge_addr: got %h expected fff", aseen); end
      n_cmp++; if (rd !== 32'hA5A55A5A) begin n_bad++; $display("FAIL edge_rdata: got %h expected a5a55a5a", rd); end
   endtask

   task automatic test_back_to_back;
      preload(4'd1, 32'h01010101);
      do_access(32'h0000_8004, 32'd0, 4'd0, 3'd0, 1'b1, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 6", lat); end
      n_cmp++; if (req0 !== 1'b0) begin n_bad++; $display("FAIL b2b_req_in_ack: got %b expected 0", req0); end
      do_access(32'h0000_8004, 32'd0, 4'd0, 3'd0, 1'b0, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
      n_cmp++; if (fst !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_in_ack: got %b expected 0", fst); end
      n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 7", lat); end
      n_cmp++; if (rd !== 32'h01010101) begin n_bad++; $display("FAIL b2b_rdata: got %h expected 01010101", rd); end
   endtask

   task automatic test_contention;
      int t0, t1;
      logic [31:0] r0, r1, first_rd, second_rd, first_op, second_op;
      t0 = 0; t1 = 0; r0 = 'x; r1 = 'x;
      preload(4'd8, 32'h11111111);
      a0 = 1'b1; addr0 = 32'h0000_8020; wdata0 = 32'hAAAA0000; dm0 = 4'd0; op0 = 3'd1;
      a1 = 1'b1; addr1 = 32'h0000_8020; wdata1 = 32'hBBBB1111; dm1 = 4'd0; op1 = 3'd1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (ack0 && t0 == 0) begin t0 = k; r0 = rdata0; a0 = 1'b0; end
         if (ack1 && t1 == 0) begin t1 = k; r1 = rdata1; a1 = 1'b0; end
         if (t0 != 0 && t1 != 0) break;
      end
      a0 = 1'b0; a1 = 1'b0;
      n_cmp++; if (t0 == 0 || t1 == 0 || t0 == t1) begin n_bad++; $display("FAIL cont_serialized: got t0=%0d t1=%0d expected distinct nonzero", t0, t1); end
      if (t0 < t1) begin first_rd = r0; second_rd = r1; first_op = 32'hAAAA0000; second_op = 32'hBBBB1111; end
      else begin first_rd = r1; second_rd = r0; first_op = 32'hBBBB1111; second_op = 32'hAAAA0000; end
      n_cmp++; if ((t0 < t1 ? t0 : t1) !== 10) begin n_bad++; $display("FAIL cont_first_latency: got %0d expected 10", (t0 < t1 ? t0 : t1)); end
      n_cmp++; if ((t0 < t1 ? t1 : t0) !== 19) begin n_bad++; $display("FAIL cont_second_latency: got %0d expected 19", (t0 < t1 ? t1 : t0)); end
      n_cmp++; if (first_rd !== 32'h11111111) begin n_bad++; $display("FAIL cont_first_old: got %h expected 11111111", first_rd); end
      n_cmp++; if (second_rd !== first_op) begin n_bad++; $display("FAIL cont_second_old: got %h expected %h", second_rd, first_op); end
      n_cmp++; if (mem[8] !== second_op) begin n_bad++; $display("FAIL cont_final_mem: got %h expected %h", mem[8], second_op); end
   endtask

   task automatic test_reset_mid;
      preload(4'd9, 32'd5);
      a0 = 1'b1; addr0 = 32'h0000_8024; wdata0 = 32'd3; dm0 = 4'd0; op0 = 3'd2;
      repeat (7) @(negedge clk);
      n_cmp++; if ({req0, dmw0} !== 5'b1_1111) begin n_bad++; $display("FAIL mid_write_phase: got %b expected 11111", {req0, dmw0}); end
      a0 = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++; if ({req0, done0, ack0, stall0, dmw0} !== 8'd0) begin n_bad++; $display("FAIL mid_reset_ctl: got %b expected 0", {req0, done0, ack0, stall0, dmw0}); end
      n_cmp++; if ({data0, oaddr0, rdata0} !== 76'd0) begin n_bad++; $display("FAIL mid_reset_data: got %h expected 0", {data0, oaddr0, rdata0}); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_access(32'h0000_8024, 32'd0, 4'd0, 3'd0, 1'b0, lat, rd, dones, gaps, stall_ok, fst, aseen, dseen);
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL after_reset_latency: got %0d expected 6", lat); end
      n_cmp++; if (rd !== 32'd5) begin n_bad++; $display("FAIL after_reset_rdata: got %h expected 00000005", rd); end
   endtask

   initial begin
      test_reset();
      test_plain_load();
      test_byte_store();
      test_amo_add();
      test_amo_ops();
      test_non_hit();
      test_window_edge();
      test_back_to_back();
      test_contention();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
